merge_pair_scheduler: RTL and testbench
=======================================

# merge_pair_scheduler

Time-multiplexes one two-input merger between NUM_PAIRS pairs of sorted-run source FIFOs. Runs are zero-terminated streams of 32-bit unsigned keys. The scheduler picks a ready pair round-robin and gates that pair's FIFO interfaces onto the merger inputs. It routes the merger output to the matching destination and releases the merger only after the merged run's terminators have drained, so runs from different pairs never interleave.

## Interface
- NUM_PAIRS, 4, number of source pairs / destinations (2..8)
- PAIR_W, 2, width of pair index, clog2(NUM_PAIRS)
- TERM_OUT, 2, zero words the merger emits per merged run
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_src_data  in  64*NUM_PAIRS  show-ahead heads; pair p side s at bits [(2p+s)*32 +: 32]
- i_src_empty  in  2*NUM_PAIRS  source empty flags, bit 2p+s
- o_src_read  out  2*NUM_PAIRS  source pop strobes
- o_m_fifo_1 / o_m_fifo_2  out  32  merger input data (side 0 / side 1)
- o_m_fifo_1_empty / o_m_fifo_2_empty  out  1  merger input empty flags
- i_m_fifo_1_read / i_m_fifo_2_read  in  1  merger pop strobes
- o_m_out_ready  out  1  ready to merger output
- i_m_out_write  in  1  merger output write strobe
- i_m_data  in  32  merger output word
- i_dst_ready  in  NUM_PAIRS  destination ready
- o_dst_write  out  NUM_PAIRS  destination write strobes
- o_dst_data  out  32  destination data (shared)
- o_busy  out  1  merger owned by a pair
- o_pair  out  PAIR_W  pair currently granted
- o_runs_done  out  16  merged runs completed, wraps at 65535

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE: a pair is eligible when both of its source empties are 0. Grant goes to the first eligible pair scanning upward from last_grant+1, mod NUM_PAIRS. last_grant resets to NUM_PAIRS-1, so pair 0 has first priority. On grant: latch o_pair, clear done_0/done_1 and term_cnt, then go to STREAM. With no eligible pair, stay in IDLE.
- STREAM:
  - Side s of the granted pair is presented to the merger: data passes through, and empty = src_empty OR done_s.
  - o_src_read[2p+s] = merger read_s AND NOT presented_empty_s, so a pop never occurs on empty.
  - Popping a word equal to 0 sets done_s.
  - When done_0 and done_1 are both set, go to DRAIN.
- DRAIN: both merger empties are held at 1.
- Output path, in STREAM and DRAIN:
  - o_m_out_ready = i_dst_ready[o_pair]; o_dst_data = i_m_data.
  - o_dst_write[o_pair] = i_m_out_write; all other bits are 0.
  - Each write with i_m_data==0 increments term_cnt.
  - When term_cnt reaches TERM_OUT: go to IDLE, set last_grant to o_pair, increment o_runs_done.
- IDLE output path: o_m_out_ready=0, o_dst_write=0. An i_m_out_write in IDLE is ignored.
- Ungranted pairs always see o_src_read=0.
- Merger input empties are 1 in IDLE.

## Timing
- Reset values: state IDLE, o_busy 0, o_pair 0, o_runs_done 0, o_src_read 0, o_dst_write 0, o_m_out_ready 0, both merger empties 1, merger data 0.
- Grant latency: a pair becoming eligible at edge N is granted at edge N+1. Its heads are visible to the merger in the cycle after N+1.
- o_src_read, the merger empties/data and the destination path are combinational from registered state and inputs. Zero added latency on data.
- STREAM to DRAIN: the edge that pops the second terminator.
- DRAIN to IDLE: the edge of the TERM_OUT-th zero write. A new grant is possible on the next edge, giving one IDLE cycle minimum between runs.
- Both terminators popped in the same cycle: straight to DRAIN.
- A zero write seen in STREAM counts toward term_cnt.
- o_dst_write is combinational from i_m_out_write. The merger must not assert write when o_m_out_ready is 0; the block does not buffer.
- Reset mid-run aborts immediately; partially consumed source runs are not recovered.
- o_runs_done wraps 65535 to 0.

## Test plan
- Pair 0 loaded with runs {3,7,0} and {5,0}, behavioural merger with TERM_OUT=2 → dst 0 receives 3,5,7,0,0; o_runs_done=1; o_busy falls on the edge of the second zero.
- All four pairs eligible from reset → grant order 0,1,2,3,0. No source pop on an ungranted pair at any cycle.
- Pair 1 eligible while pair 2 is in DRAIN → pair 1 granted exactly one edge after pair 2 releases, and not before term_cnt reaches 2.
- Side 1 terminator popped while side 0 still holds 9,0 → side 1 empty held at 1. No further side-1 pops. 9 is still merged before DRAIN.
- i_dst_ready[0] low for 5 cycles mid-run → o_m_out_ready=0 for those 5 cycles; no dst write; no data lost after resume.
- Reset asserted in STREAM → all outputs return to reset values within the same cycle (async). Pair 0 is re-granted first after release.

Source files
------------

// File: rtl/merge_pair_scheduler.sv
// Round-robin scheduler sharing one two-input merger between NUM_PAIRS source pairs.
// A granted pair owns the merger until TERM_OUT zero words have been written out.
module merge_pair_scheduler #(
  parameter int unsigned NUM_PAIRS = 4,
  parameter int unsigned PAIR_W    = 2,
  parameter int unsigned TERM_OUT  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [64*NUM_PAIRS-1:0]   i_src_data,
  input  logic [2*NUM_PAIRS-1:0]    i_src_empty,
  output logic [2*NUM_PAIRS-1:0]    o_src_read,
  output logic [31:0]               o_m_fifo_1,
  output logic [31:0]               o_m_fifo_2,
  output logic                      o_m_fifo_1_empty,
  output logic                      o_m_fifo_2_empty,
  input  logic                      i_m_fifo_1_read,
  input  logic                      i_m_fifo_2_read,
  output logic                      o_m_out_ready,
  input  logic                      i_m_out_write,
  input  logic [31:0]               i_m_data,
  input  logic [NUM_PAIRS-1:0]      i_dst_ready,
  output logic [NUM_PAIRS-1:0]      o_dst_write,
  output logic [31:0]               o_dst_data,
  output logic                      o_busy,
  output logic [PAIR_W-1:0]         o_pair,
  output logic [15:0]               o_runs_done
);

  localparam int unsigned TERM_W = $clog2(TERM_OUT + 1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e              state_q, state_d;
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic [PAIR_W-1:0]   last_q, last_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [TERM_W-1:0]   term_q, term_d;
  logic [15:0]         runs_q, runs_d;

  logic [31:0]         heads [2*NUM_PAIRS];
  logic [NUM_PAIRS-1:0] elig;
  logic                grant_valid;
  logic [PAIR_W-1:0]   grant_idx;
  int unsigned         scan;
  logic [PAIR_W-1:0]   scan_w;

  logic [PAIR_W:0]     sidx0, sidx1;
  logic [31:0]         head0, head1;
  logic                m_empty0, m_empty1;
  logic                pop0, pop1;
  logic                zero_wr;

  always_comb begin
    for (int unsigned k = 0; k < 2 * NUM_PAIRS; k++) begin
      heads[k] = i_src_data[k*32 +: 32];
    end
    for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
      elig[p] = ~i_src_empty[2*p] & ~i_src_empty[2*p+1];
    end
  end

  // First eligible pair scanning upward from the one after the last grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    scan_w      = '0;
    for (int unsigned i = 1; i <= NUM_PAIRS; i++) begin
      scan   = (32'(last_q) + i) % NUM_PAIRS;
      scan_w = PAIR_W'(scan);
      if (!grant_valid && elig[scan_w]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_w;
      end
    end
  end

  assign sidx0 = {pair_q, 1'b0};
  assign sidx1 = {pair_q, 1'b1};
  assign head0 = heads[sidx0];
  assign head1 = heads[sidx1];

  always_comb begin
    m_empty0      = 1'b1;
    m_empty1      = 1'b1;
    o_m_fifo_1    = '0;
    o_m_fifo_2    = '0;
    pop0          = 1'b0;
    pop1          = 1'b0;
    o_src_read    = '0;
    o_m_out_ready = 1'b0;
    o_dst_write   = '0;
    o_dst_data    = '0;
    if (state_q == StStream) begin
      o_m_fifo_1        = head0;
      o_m_fifo_2        = head1;
      m_empty0          = i_src_empty[sidx0] | done0_q;
      m_empty1          = i_src_empty[sidx1] | done1_q;
      pop0              = i_m_fifo_1_read & ~m_empty0;
      pop1              = i_m_fifo_2_read & ~m_empty1;
      o_src_read[sidx0] = pop0;
      o_src_read[sidx1] = pop1;
    end
    if (state_q != StIdle) begin
      o_m_out_ready       = i_dst_ready[pair_q];
      o_dst_data          = i_m_data;
      o_dst_write[pair_q] = i_m_out_write;
    end
  end

  assign o_m_fifo_1_empty = m_empty0;
  assign o_m_fifo_2_empty = m_empty1;
  assign zero_wr = (state_q != StIdle) && i_m_out_write && (i_m_data == '0);

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    last_d  = last_q;
    done0_d = done0_q;
    done1_d = done1_q;
    term_d  = term_q;
    runs_d  = runs_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          pair_d  = grant_idx;
          done0_d = 1'b0;
          done1_d = 1'b0;
          term_d  = '0;
          state_d = StStream;
        end
      end
      StStream, StDrain: begin
        if (pop0 && head0 == '0) done0_d = 1'b1;
        if (pop1 && head1 == '0) done1_d = 1'b1;
        if (zero_wr) term_d = term_q + TERM_W'(1);
        // Release takes priority: the merger is done once its terminators are out.
        if (zero_wr && term_d == TERM_W'(TERM_OUT)) begin
          state_d = StIdle;
          last_d  = pair_q;
          runs_d  = runs_q + 16'd1;
        end else if (state_q == StStream && done0_d && done1_d) begin
          state_d = StDrain;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      pair_q  <= '0;
      last_q  <= PAIR_W'(NUM_PAIRS - 1);
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      term_q  <= '0;
      runs_q  <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      last_q  <= last_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      term_q  <= term_d;
      runs_q  <= runs_d;
    end
  end

  assign o_busy      = (state_q != StIdle);
  assign o_pair      = pair_q;
  assign o_runs_done = runs_q;

endmodule

// File: tb/tb_merge_pair_scheduler.sv
// Directed bench for merge_pair_scheduler: source FIFO models, a behavioural merger
// and destination logs around the DUT, with hand-computed expected sequences.
module tb_merge_pair_scheduler;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam int TO = 2;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [64*NP-1:0]  i_src_data;
  logic [2*NP-1:0]   i_src_empty;
  logic [2*NP-1:0]   o_src_read;
  logic [31:0]       o_m_fifo_1, o_m_fifo_2;
  logic              o_m_fifo_1_empty, o_m_fifo_2_empty;
  logic              i_m_fifo_1_read, i_m_fifo_2_read;
  logic              o_m_out_ready;
  logic              i_m_out_write;
  logic [31:0]       i_m_data;
  logic [NP-1:0]     i_dst_ready = '1;
  logic [NP-1:0]     o_dst_write;
  logic [31:0]       o_dst_data;
  logic              o_busy;
  logic [PW-1:0]     o_pair;
  logic [15:0]       o_runs_done;

  merge_pair_scheduler #(.NUM_PAIRS(NP), .PAIR_W(PW), .TERM_OUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_src_data(i_src_data), .i_src_empty(i_src_empty), .o_src_read(o_src_read),
    .o_m_fifo_1(o_m_fifo_1), .o_m_fifo_2(o_m_fifo_2),
    .o_m_fifo_1_empty(o_m_fifo_1_empty), .o_m_fifo_2_empty(o_m_fifo_2_empty),
    .i_m_fifo_1_read(i_m_fifo_1_read), .i_m_fifo_2_read(i_m_fifo_2_read),
    .o_m_out_ready(o_m_out_ready), .i_m_out_write(i_m_out_write), .i_m_data(i_m_data),
    .i_dst_ready(i_dst_ready), .o_dst_write(o_dst_write), .o_dst_data(o_dst_data),
    .o_busy(o_busy), .o_pair(o_pair), .o_runs_done(o_runs_done)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Source FIFOs: append-only storage, read pointer advanced by DUT pops.
  int unsigned src_mem [2*NP][32];
  int          src_len [2*NP] = '{default: 0};
  int          src_rd  [2*NP] = '{default: 0};

  task automatic push(input int k, input int unsigned v);
    src_mem[k][src_len[k]] = v;
    src_len[k] = src_len[k] + 1;
  endtask

  always_comb begin
    for (int k = 0; k < 2 * NP; k++) begin
      i_src_empty[k]          = (src_rd[k] >= src_len[k]);
      i_src_data[k*32 +: 32]  = i_src_empty[k] ? 32'd0 : src_mem[k][src_rd[k] % 32];
    end
  end

  // Behavioural merger: terminator pops first, then smallest head, then TO zeros.
  logic m_done0 = 1'b0, m_done1 = 1'b0;
  int   m_zeros = 0;
  logic a_ok, b_ok;

  always_comb begin
    i_m_fifo_1_read = 1'b0;
    i_m_fifo_2_read = 1'b0;
    i_m_out_write   = 1'b0;
    i_m_data        = 32'd0;
    a_ok            = !o_m_fifo_1_empty;
    b_ok            = !o_m_fifo_2_empty;
    if (i_rst_n && o_m_out_ready) begin
      if (a_ok && o_m_fifo_1 == 0) i_m_fifo_1_read = 1'b1;
      else if (b_ok && o_m_fifo_2 == 0) i_m_fifo_2_read = 1'b1;
      else if (m_done0 && m_done1) i_m_out_write = 1'b1;
      else if (a_ok && (m_done1 || (b_ok && o_m_fifo_1 <= o_m_fifo_2))) begin
        i_m_fifo_1_read = 1'b1;
        i_m_out_write   = 1'b1;
        i_m_data        = o_m_fifo_1;
      end else if (b_ok && (m_done0 || a_ok)) begin
        i_m_fifo_2_read = 1'b1;
        i_m_out_write   = 1'b1;
        i_m_data        = o_m_fifo_2;
      end
    end
  end

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_done0 <= 1'b0;
      m_done1 <= 1'b0;
      m_zeros <= 0;
    end else begin
      if (i_m_fifo_1_read && o_m_fifo_1 == 0) m_done0 <= 1'b1;
      if (i_m_fifo_2_read && o_m_fifo_2 == 0) m_done1 <= 1'b1;
      if (i_m_out_write && i_m_data == 0) begin
        if (m_zeros + 1 == TO) begin
          m_done0 <= 1'b0;
          m_done1 <= 1'b0;
          m_zeros <= 0;
        end else begin
          m_zeros <= m_zeros + 1;
        end
      end
    end
  end

  // Source pops, destination logs and edge counter.
  int          cyc = 0;
  int unsigned dst_log [NP][64];
  int          dst_cnt [NP] = '{default: 0};
  int          last_zero_cyc [NP] = '{default: 0};

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2 * NP; k++) if (o_src_read[k]) src_rd[k] <= src_rd[k] + 1;
    for (int d = 0; d < NP; d++) begin
      if (o_dst_write[d] && dst_cnt[d] < 64) begin
        dst_log[d][dst_cnt[d]] <= o_dst_data;
        dst_cnt[d] <= dst_cnt[d] + 1;
        if (o_dst_data == 0) last_zero_cyc[d] <= cyc;
      end
    end
  end

  // Grant/release log and illegal-pop / held-empty monitors.
  logic busy_prev = 1'b0;
  int   grant_log [64];
  int   rise_log [64];
  int   fall_log [64];
  int   n_grant = 0, n_fall = 0;
  int   bad_pop = 0, held_viol = 0;

  always @(negedge i_clk) begin
    busy_prev <= o_busy;
    if (o_busy && !busy_prev && n_grant < 64) begin
      grant_log[n_grant] <= int'(o_pair);
      rise_log[n_grant]  <= cyc - 1;
      n_grant            <= n_grant + 1;
    end
    if (!o_busy && busy_prev && n_fall < 64) begin
      fall_log[n_fall] <= cyc - 1;
      n_fall           <= n_fall + 1;
    end
    for (int k = 0; k < 2 * NP; k++) begin
      if (o_src_read[k] && (!o_busy || int'(o_pair) != k / 2 || i_src_empty[k]))
        bad_pop <= bad_pop + 1;
    end
    if (o_busy && ((m_done0 && !o_m_fifo_1_empty) || (m_done1 && !o_m_fifo_2_empty)))
      held_viol <= held_viol + 1;
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic wait_runs(input int target, input string tag);
    int n = 0;
    while (int'(o_runs_done) != target && n < 300) begin
      step();
      n++;
    end
    check_eq(tag, 32'(o_runs_done), 32'(target));
  endtask

  task automatic wait_grant(input int p, input string tag);
    int n = 0;
    while (!(o_busy && int'(o_pair) == p) && n < 300) begin
      step();
      n++;
    end
    check_eq(tag, 32'({o_busy, o_pair}), 32'({1'b1, PW'(p)}));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " busy"}, 32'(o_busy), 0);
    check_eq({tag, " pair"}, 32'(o_pair), 0);
    check_eq({tag, " runs"}, 32'(o_runs_done), 0);
    check_eq({tag, " src_read"}, 32'(o_src_read), 0);
    check_eq({tag, " dst_write"}, 32'(o_dst_write), 0);
    check_eq({tag, " out_ready"}, 32'(o_m_out_ready), 0);
    check_eq({tag, " empties"}, 32'({o_m_fifo_1_empty, o_m_fifo_2_empty}), 3);
    check_eq({tag, " m_data"}, o_m_fifo_1 | o_m_fifo_2, 0);
  endtask

  int unsigned exp0 [30] = '{3, 5, 7, 0, 0,  9, 0, 0,  4, 11, 0, 0,  10, 20, 30, 40, 0, 0,
                             1, 2, 0, 0,  5, 6, 0, 0,  7, 8, 0, 0};
  int          exp_order [5] = '{0, 1, 2, 3, 0};
  int          base, cnt_hold, fall_p2;

  initial begin
    repeat (3) step();
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    step();

    // Basic run on pair 0.
    push(0, 3); push(0, 7); push(0, 0);
    push(1, 5); push(1, 0);
    wait_runs(1, "basic runs_done");
    for (int i = 0; i < 5; i++) check_eq("basic dst0", dst_log[0][i], exp0[i]);
    check_eq("basic dst0 count", 32'(dst_cnt[0]), 5);
    check_eq("busy falls on 2nd zero", 32'(fall_log[n_fall-1]), 32'(last_zero_cyc[0]));

    // Side 1 terminates early while the next run already sits behind it.
    push(1, 0); push(1, 11); push(1, 0);
    push(0, 9); push(0, 0);
    wait_runs(2, "early term runs_done");
    check_eq("side1 run held back", 32'(src_len[1] - src_rd[1]), 2);
    push(0, 4); push(0, 0);
    wait_runs(3, "follow-on runs_done");
    for (int i = 5; i < 12; i++) check_eq("early term dst0", dst_log[0][i], exp0[i]);

    // Destination back-pressure mid-run.
    push(0, 10); push(0, 30); push(0, 0);
    push(1, 20); push(1, 40); push(1, 0);
    for (int n = 0; n < 300 && dst_cnt[0] < 14; n++) step();
    check_eq("stall start count", 32'(dst_cnt[0]), 14);
    i_dst_ready[0] = 1'b0;
    #1;
    cnt_hold = dst_cnt[0];
    for (int i = 0; i < 5; i++) begin
      check_eq("stall out_ready", 32'(o_m_out_ready), 0);
      check_eq("stall dst_write", 32'(o_dst_write), 0);
      step();
    end
    check_eq("stall no writes", 32'(dst_cnt[0]), 32'(cnt_hold));
    i_dst_ready[0] = 1'b1;
    wait_runs(4, "stall runs_done");
    for (int i = 12; i < 18; i++) check_eq("stall dst0", dst_log[0][i], exp0[i]);

    // All pairs eligible from reset: round-robin order.
    i_rst_n = 1'b0;
    step();
    push(0, 1); push(0, 0); push(0, 5); push(0, 0);
    push(1, 2); push(1, 0); push(1, 6); push(1, 0);
    for (int p = 1; p < NP; p++) begin
      push(2*p, 10*p + 1); push(2*p, 0);
      push(2*p + 1, 10*p + 2); push(2*p + 1, 0);
    end
    step();
    base = n_grant;
    i_rst_n = 1'b1;
    wait_runs(5, "rr runs_done");
    check_eq("rr grant count", 32'(n_grant - base), 5);
    for (int i = 0; i < 5; i++) check_eq("rr order", 32'(grant_log[base+i]), 32'(exp_order[i]));
    for (int i = 18; i < 26; i++) check_eq("rr dst0", dst_log[0][i], exp0[i]);
    check_eq("rr dst2 first", dst_log[2][0], 21);
    check_eq("rr dst3 second", dst_log[3][1], 32);

    // Pair 1 waits for pair 2 to release.
    push(4, 50); push(4, 0); push(5, 60); push(5, 0);
    wait_grant(2, "p2 grant");
    push(2, 15); push(2, 0); push(3, 16); push(3, 0);
    wait_runs(7, "p2/p1 runs_done");
    check_eq("p2 then p1", 32'(grant_log[n_grant-1]), 1);
    fall_p2 = fall_log[n_fall-2];
    check_eq("p1 grant one edge after release", 32'(rise_log[n_grant-1]), 32'(fall_p2 + 1));
    check_eq("p2 release on 2nd zero", 32'(fall_p2), 32'(last_zero_cyc[2]));
    check_eq("p2 dst2 word", dst_log[2][5], 60);
    check_eq("p1 dst1 word", dst_log[1][5], 16);

    // Asynchronous reset in the middle of a pair-3 run.
    push(6, 70); push(6, 80); push(6, 0);
    push(7, 75); push(7, 0);
    wait_grant(3, "p3 grant");
    #1 i_rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    push(0, 7); push(0, 0); push(1, 8); push(1, 0);
    step();
    i_rst_n = 1'b1;
    wait_grant(0, "pair 0 first after reset");
    wait_runs(1, "post-reset runs_done");
    for (int i = 26; i < 30; i++) check_eq("post-reset dst0", dst_log[0][i], exp0[i]);

    check_eq("no illegal pops", 32'(bad_pop), 0);
    check_eq("done side held empty", 32'(held_viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
